// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG word collector.
package trng_pkg;

    localparam int TRNG_DATA_WIDTH = 32;
    localparam int TRNG_FIFO_DEPTH = 4;
    localparam int TRNG_RCT_LIMIT  = 64;

    // Von Neumann pair tracker: waiting for first bit, or holding it.
    typedef enum logic {
        PAIR_IDLE = 1'b0,
        PAIR_HAVE = 1'b1
    } pair_state_e;

endpackage

// File: rtl/trng_word_fifo.sv
// Show-ahead word FIFO with push, pop, flush and level output.
// The head word is always presented on rd_data; rd_valid means non-empty.
// A push into a full FIFO is refused (drop) unless a pop happens on the same edge.
module trng_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
    assign level    = count;

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Word storage; cleared on reset and flush so stale entropy never reappears.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage is small and must read 0 after reset, so it is reset explicitly rather than left to a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/trng_word_collector.sv
// TRNG entropy conditioning and word buffering ahead of the register slave.
// Raw bits pass a repetition-count health test, optional von Neumann
// debiasing (define TRNG_VN_DEBIAS_EN), are packed MSB-first into words and
// buffered in a show-ahead FIFO popped by the register slave.
module trng_word_collector
    import trng_pkg::*;
#(
    parameter int DATA_WIDTH = TRNG_DATA_WIDTH,
    parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
    parameter int RCT_LIMIT  = TRNG_RCT_LIMIT
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          enable,
    input  logic                          raw_valid,
    input  logic                          raw_bit,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          health_fail,
    input  logic                          status_clr
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);

    logic                  accept;
    logic [RCT_W-1:0]      rct_cnt;
    logic [RCT_W-1:0]      rct_base;
    logic [RCT_W-1:0]      rct_next;
    logic                  last_bit;
    logic                  rct_trip;
    logic                  cond_valid;
    logic                  cond_bit;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  fifo_drop;

    // Once the health test trips, the source is distrusted until software clears it.
    assign accept = raw_valid && enable && !health_fail;

    // ------------------------------------------------------------------
    // Repetition-count health test on raw accepted bits
    // ------------------------------------------------------------------

    // Next repetition count; a same-cycle clear restarts the run from this bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rct_base = status_clr ? '0 : rct_cnt;
        rct_next = RCT_W'(1);
        if (rct_base != '0 && raw_bit == last_bit) begin
            if (rct_base == RCT_W'(RCT_LIMIT)) rct_next = rct_base;
            else                               rct_next = rct_base + RCT_W'(1);
        end
    end

    assign rct_trip = accept && (rct_next == RCT_W'(RCT_LIMIT));

    // Repetition counter and last raw bit seen.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rct_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (accept) begin
            rct_cnt  <= rct_next;
            last_bit <= raw_bit;
        end else if (status_clr) begin
            rct_cnt  <= '0;
        end
    end

    // Sticky status flags; a set on the same edge beats a clear.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            health_fail <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (rct_trip)        health_fail <= 1'b1;
            else if (status_clr) health_fail <= 1'b0;
            if (fifo_drop)       overflow    <= 1'b1;
            else if (status_clr) overflow    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Conditioning
    // ------------------------------------------------------------------
`ifdef TRNG_VN_DEBIAS_EN
    pair_state_e state;
    pair_state_e state_next;
    logic        pair_bit;

    // Pair state register, plus the first bit of the pending pair.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state    <= PAIR_IDLE;
            pair_bit <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && state == PAIR_IDLE) pair_bit <= raw_bit;
        end
    end

    // Next pair state; disabling or a health trip discards a pending pair.
    always_comb begin
        state_next = state;
        if (!enable || rct_trip) begin
            state_next = PAIR_IDLE;
        end else if (accept) begin
            case (state)
                PAIR_IDLE: state_next = PAIR_HAVE;
                PAIR_HAVE: state_next = PAIR_IDLE;
                default:   state_next = PAIR_IDLE;
            endcase
        end
    end

    // Emit the first bit of a differing pair (10 -> 1, 01 -> 0).
    always_comb begin
        cond_valid = 1'b0;
        cond_bit   = pair_bit;
        if (accept && state == PAIR_HAVE && raw_bit != pair_bit) cond_valid = 1'b1;
    end
`else
    assign cond_valid = accept;
    assign cond_bit   = raw_bit;
`endif

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    assign push_word = {shift_reg[DATA_WIDTH-2:0], cond_bit};
    assign word_done = cond_valid && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign fifo_push = word_done && !rct_trip;

    // Shift conditioned bits in at the LSB; the counter wraps after each word.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (!enable || rct_trip) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (cond_valid) begin
            shift_reg <= push_word;
            bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    trng_word_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .push     (fifo_push),
        .wr_data  (push_word),
        .pop      (rd_en),
        .flush    (rct_trip),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (fifo_level),
        .drop     (fifo_drop)
    );

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed self-checking bench for trng_word_collector; adapts the raw bit
// stream and expected levels to whether TRNG_VN_DEBIAS_EN is defined.
module tb_trng_word_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        raw_valid = 1'b0;
    logic        raw_bit = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        health_fail;
    logic        status_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] words [5] = '{32'h12345678, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hCAFEBABE};

`ifdef TRNG_VN_DEBIAS_EN
    localparam int PRE_TRIP_LEVEL = 1;
`else
    localparam int PRE_TRIP_LEVEL = 3;
`endif

    trng_word_collector dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .enable        (enable),
        .raw_valid     (raw_valid),
        .raw_bit       (raw_bit),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .health_fail   (health_fail),
        .status_clr    (status_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One raw bit on one clock edge, optionally popping on that same edge.
    task automatic send_raw(input logic b, input logic pop);
        raw_valid = 1'b1;
        raw_bit   = b;
        rd_en     = pop;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
        rd_en     = 1'b0;
    endtask

    // One conditioned bit: a differing pair when debiasing, else the bit itself.
    task automatic send_cbit(input logic b, input logic pop_last);
`ifdef TRNG_VN_DEBIAS_EN
        send_raw(b, 1'b0);
        send_raw(~b, pop_last);
`else
        send_raw(b, pop_last);
`endif
    endtask

    task automatic send_cbits(input logic [31:0] w, input int n);
        for (int i = 31; i > 31 - n; i--) send_cbit(w[i], 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic pop_last);
        send_cbits(w, 31);
        send_cbit(w[0], pop_last);
    endtask

    task automatic pop_word();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        @(posedge clk);
        #1;
        status_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_health", 32'(health_fail), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;

        // First word: rd_valid only after the final raw bit's edge
        send_cbits(32'hAAAAAAAA, 31);
        check("first_word_not_yet", 32'(rd_valid), 32'd0);
`ifdef TRNG_VN_DEBIAS_EN
        send_raw(1'b0, 1'b0);
        check("first_word_half_pair", 32'(rd_valid), 32'd0);
        send_raw(1'b1, 1'b0);
`else
        send_raw(1'b0, 1'b0);
`endif
        check("first_word_valid", 32'(rd_valid), 32'd1);
        check("first_word_data", rd_data, 32'hAAAAAAAA);
        check("first_word_level", 32'(fifo_level), 32'd1);
        pop_word();
        check("pop_empty_level", 32'(fifo_level), 32'd0);
        check("pop_empty_valid", 32'(rd_valid), 32'd0);
        pop_word();
        check("pop_when_empty", 32'(fifo_level), 32'd0);

`ifdef TRNG_VN_DEBIAS_EN
        // Equal pairs produce nothing
        for (int i = 0; i < 50; i++) begin
            send_raw(i[0], 1'b0);
            send_raw(i[0], 1'b0);
        end
        check("equal_pairs_level", 32'(fifo_level), 32'd0);
        check("equal_pairs_health", 32'(health_fail), 32'd0);
`endif

        // Dropping enable discards the partial word
        for (int i = 0; i < 10; i++) send_raw(i[0], 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        send_word(32'h12345678, 1'b0);
        check("enable_discard_data", rd_data, 32'h12345678);
        check("enable_discard_level", 32'(fifo_level), 32'd1);
        pop_word();

        // Overflow: fifth word is dropped
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_no_overflow", 32'(overflow), 32'd0);
        send_word(words[4], 1'b0);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_level", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_order_%0d", i), rd_data, words[i]);
            pop_word();
        end
        check("drain_level", 32'(fifo_level), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);
        clear_status();
        check("overflow_cleared", 32'(overflow), 32'd0);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
        send_word(words[4], 1'b1);
        check("push_pop_full_overflow", 32'(overflow), 32'd0);
        check("push_pop_full_level", 32'(fifo_level), 32'd4);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("push_pop_order_%0d", i), rd_data, words[i]);
            pop_word();
        end
        check("push_pop_drained", 32'(fifo_level), 32'd0);

        // Health test: 64 identical raw bits trip and flush
        send_word(32'h12345678, 1'b0);
        send_raw(1'b0, 1'b0);
        for (int i = 0; i < 63; i++) send_raw(1'b1, 1'b0);
        check("rct_pre_trip_health", 32'(health_fail), 32'd0);
        check("rct_pre_trip_level", 32'(fifo_level), 32'(PRE_TRIP_LEVEL));
        check("rct_pre_trip_head", rd_data, 32'h12345678);
        send_raw(1'b1, 1'b0);
        check("rct_trip_health", 32'(health_fail), 32'd1);
        check("rct_trip_level", 32'(fifo_level), 32'd0);
        check("rct_trip_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 40; i++) send_raw(i[0], 1'b0);
        check("rct_ignored_level", 32'(fifo_level), 32'd0);
        check("rct_still_failed", 32'(health_fail), 32'd1);
        clear_status();
        check("rct_cleared", 32'(health_fail), 32'd0);
        send_word(32'hA5A5A5A5, 1'b0);
        check("rct_resume_data", rd_data, 32'hA5A5A5A5);
        check("rct_resume_level", 32'(fifo_level), 32'd1);

        // Reset mid-word discards everything
        for (int i = 0; i < 20; i++) send_raw(i[1], 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_rd_data", rd_data, 32'h0);
        check("midreset_valid", 32'(rd_valid), 32'd0);
        check("midreset_level", 32'(fifo_level), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h12345678, 1'b0);
        check("post_reset_data", rd_data, 32'h12345678);
        check("post_reset_level", 32'(fifo_level), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
